// File: rtl/sha256_block_sequencer.sv
// Fetches message words, applies SHA-256 padding, streams 16-word blocks to the
// compression core and writes the final digest back to memory.
module sha256_block_sequencer #(
    parameter int MEM_RD_LAT = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [31:0]  message_addr,
    input  logic [31:0]  size,
    input  logic [31:0]  output_addr,
    output logic         done,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic         w_first,
    input  logic         core_done,
    input  logic [255:0] hash_in
);
    localparam int CW = $clog2(MEM_RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, CORE, WRITE, DONE} state_t;

    state_t        state;
    logic [31:0]   g;
    logic [31:0]   size_r;
    logic [31:0]   last_blk;
    logic [15:0]   msg_addr;
    logic [15:0]   out_addr;
    logic [CW-1:0] cnt;
    logic [2:0]    k;
    logic [31:0]   g_inc;
    logic          unused_hi;

    assign mem_clk   = clk;
    assign g_inc     = g + 32'd1;
    assign unused_hi = ^{message_addr[31:16], output_addr[31:16]};

    // Only words that carry message bytes touch memory; pure padding words do not.
    function automatic logic need_read(input logic [31:0] gi, input logic [31:0] sz);
        need_read = (gi < (sz >> 2)) || ((gi == (sz >> 2)) && (sz[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] form_word(input logic [31:0] gi, input logic [31:0] sz,
                                              input logic [31:0] lastb, input logic [31:0] rd);
        logic [31:0] nw;
        logic        last;
        nw        = sz >> 2;
        last      = ((gi >> 4) == lastb);
        form_word = 32'h0;
        if (gi < nw) begin
            form_word = rd;
        end else if (gi == nw) begin
            case (sz[1:0])
                2'd0:    form_word = 32'h8000_0000;
                2'd1:    form_word = {rd[31:24], 24'h80_0000};
                2'd2:    form_word = {rd[31:16], 16'h8000};
                default: form_word = {rd[31:8], 8'h80};
            endcase
        end else if (last && gi[3:0] == 4'd14) begin
            form_word = {29'd0, sz[31:29]};
        end else if (last && gi[3:0] == 4'd15) begin
            form_word = sz << 3;
        end
    endfunction

    function automatic logic [31:0] hash_word(input logic [255:0] h, input logic [2:0] idx);
        hash_word = h[255 - 32*int'(idx) -: 32];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'h0;
            mem_write_data <= 32'h0;
            w_valid        <= 1'b0;
            w_first        <= 1'b0;
            w_data         <= 32'h0;
            g              <= 32'h0;
            size_r         <= 32'h0;
            last_blk       <= 32'h0;
            msg_addr       <= 16'h0;
            out_addr       <= 16'h0;
            cnt            <= '0;
            k              <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        size_r   <= size;
                        last_blk <= (size + 32'd8) >> 6;
                        msg_addr <= message_addr[15:0];
                        out_addr <= output_addr[15:0];
                        g        <= 32'h0;
                        state    <= FETCH;
                        if (need_read(32'h0, size)) mem_addr <= message_addr[15:0];
                    end
                end
                // mem_addr was loaded on entry, so the read latency starts with this cycle
                FETCH: begin
                    if (need_read(g, size_r)) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        w_data  <= form_word(g, size_r, last_blk, 32'h0);
                        w_valid <= 1'b1;
                        w_first <= (g[31:4] == 28'd0);
                        state   <= PRESENT;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(MEM_RD_LAT - 1)) begin
                        w_data  <= form_word(g, size_r, last_blk, mem_read_data);
                        w_valid <= 1'b1;
                        w_first <= (g[31:4] == 28'd0);
                        state   <= PRESENT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESENT: begin
                    if (w_ready) begin
                        w_valid <= 1'b0;
                        w_first <= 1'b0;
                        g       <= g_inc;
                        if (g[3:0] == 4'hF) begin
                            state <= CORE;
                        end else begin
                            state <= FETCH;
                            if (need_read(g_inc, size_r)) mem_addr <= msg_addr + g_inc[15:0];
                        end
                    end
                end
                CORE: begin
                    if (core_done) begin
                        if ((g >> 4) <= last_blk) begin
                            state <= FETCH;
                            if (need_read(g, size_r)) mem_addr <= msg_addr + g[15:0];
                        end else begin
                            state          <= WRITE;
                            k              <= 3'd0;
                            mem_we         <= 1'b1;
                            mem_addr       <= out_addr;
                            mem_write_data <= hash_word(hash_in, 3'd0);
                        end
                    end
                end
                WRITE: begin
                    if (k == 3'd7) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        k              <= k + 3'd1;
                        mem_addr       <= out_addr + 16'(k) + 16'd1;
                        mem_write_data <= hash_word(hash_in, k + 3'd1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
